// File: rtl/ram8_write_arbiter.sv
// -----------------------------------------------------------------------------
// ram8_write_arbiter
//
// Round-robin write arbiter that shares one 8-entry bank of 16-bit registers
// between four requesters. One winner at a time is granted a single-cycle
// write slot. The bank's load/address/data inputs are driven for exactly
// that cycle, and the winner gets a one-cycle acknowledge in the same cycle.
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst_n      in   synchronous active-low reset
//   req        in   [N_REQ]          per-requester write request
//   req_addr   in   [N_REQ*ADDR_W]   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   in   [N_REQ*WIDTH]    packed data, requester i at [i*WIDTH +: WIDTH]
//   ack        out  [N_REQ]          one-hot, one-cycle acknowledge
//   bank_load  out                   bank write strobe
//   bank_addr  out  [ADDR_W]         bank register select
//   bank_data  out  [WIDTH]          bank write data
//   busy       out                   high while a write is being issued
//   grant_id   out  [2]              index of the current or most recent winner
// -----------------------------------------------------------------------------
module ram8_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      bank_load,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [WIDTH-1:0]          bank_data,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_ptr;
    logic [N_REQ-1:0]    r_ack;
    logic                r_bank_load;
    logic [ADDR_W-1:0]   r_bank_addr;
    logic [WIDTH-1:0]    r_bank_data;
    logic                r_busy;
    logic [1:0]          r_grant_id;

    // Per-requester unpacked views of the packed request buses.
    logic [ADDR_W-1:0]   w_addr_slice [N_REQ];
    logic [WIDTH-1:0]    w_data_slice [N_REQ];

    // w_scan_idx[k] is the requester examined at scan position k, i.e.
    // (ptr + k) mod 4; w_scan_req[k] is that requester's req bit.
    logic [1:0]          w_scan_idx [N_REQ];
    logic [N_REQ-1:0]    w_scan_req;

    logic                w_any_req;
    logic [1:0]          w_win;
    logic [N_REQ-1:0]    w_win_onehot;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [WIDTH-1:0]    w_win_data;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_data_slice[gi] = req_data[gi*WIDTH +: WIDTH];
        // 2-bit add wraps naturally, giving the modulo-4 rotation.
        assign w_scan_idx[gi]   = r_ptr + 2'(gi);
        assign w_scan_req[gi]   = req[w_scan_idx[gi]];
    end

    assign w_any_req = |req;

    // First set bit in scan order wins. Walking the scan positions from the
    // far end down to position 0 lets the nearest one overwrite the others.
    always_comb begin
        w_win = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_scan_req[k]) begin
                w_win = w_scan_idx[k];
            end
        end
    end

    assign w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_win_addr   = w_addr_slice[w_win];
    assign w_win_data   = w_data_slice[w_win];

    // Outputs are registered so that during the WRITE cycle the strobe,
    // acknowledge, address and data all come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_ack       <= '0;
            r_bank_load <= 1'b0;
            r_bank_addr <= '0;
            r_bank_data <= '0;
            r_busy      <= 1'b0;
            r_grant_id  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_WRITE;
                        r_bank_addr <= w_win_addr;
                        r_bank_data <= w_win_data;
                        r_grant_id  <= w_win;
                        r_ack       <= w_win_onehot;
                        r_bank_load <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_ack       <= '0;
                        r_bank_load <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // req is ignored here; the winner drops to lowest
                    // priority for the next arbitration.
                    r_state     <= ST_IDLE;
                    r_ptr       <= r_grant_id + 2'd1;
                    r_ack       <= '0;
                    r_bank_load <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ack       <= '0;
                    r_bank_load <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign bank_load = r_bank_load;
    assign bank_addr = r_bank_addr;
    assign bank_data = r_bank_data;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_ram8_write_arbiter.sv
module tb_ram8_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        bank_load;
    logic [2:0]  bank_addr;
    logic [15:0] bank_data;
    logic        busy;
    logic [1:0]  grant_id;

    logic [2:0]  a [4];
    logic [15:0] d [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
        assign req_addr[gi*3 +: 3]   = a[gi];
        assign req_data[gi*16 +: 16] = d[gi];
    end

    ram8_write_arbiter #(.N_REQ(4), .WIDTH(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .bank_load (bank_load),
        .bank_addr (bank_addr),
        .bank_data (bank_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // Register bank model: captures on the rising edge whenever load is high.
    logic [15:0] bank_m [8];
    always @(posedge clk) begin
        if (bank_load === 1'b1) bank_m[bank_addr] <= bank_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          g;
        logic [2:0]  addr;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int g, input logic [2:0] ad, input logic [15:0] da);
        exp_t e;
        e.g = g; e.addr = ad; e.data = da;
        q.push_back(e);
    endtask

    // Scoreboard: every write the DUT issues is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
        chk("ack_vs_load", 64'(ack != 4'd0), 64'(bank_load));
        chk("busy_vs_load", 64'(busy), 64'(bank_load));
        if (bank_load === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write_qsize", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                $display("t=%0t write grant=%0d ack=%b addr=%0d data=%h (exp grant=%0d addr=%0d data=%h)",
                         $time, grant_id, ack, bank_addr, bank_data, e.g, e.addr, e.data);
                chk("wr_ack", 64'(ack), 64'(4'b0001 << e.g));
                chk("wr_grant_id", 64'(grant_id), 64'(e.g));
                chk("wr_addr", 64'(bank_addr), 64'(e.addr));
                chk("wr_data", 64'(bank_data), 64'(e.data));
            end
        end
    end

    // Waits (bounded) for the next write cycle; g = -1 on timeout.
    task automatic wait_ack(output int g);
        g = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bank_load === 1'b1) begin
                g = int'(grant_id);
                break;
            end
        end
        checks++;
        assert (g >= 0) else begin
            failures++;
            $error("FAIL ack_timeout observed=no_ack expected=ack_within_20_cycles");
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_ack"}, 64'(ack), 64'd0);
        chk({pfx, "_bank_load"}, 64'(bank_load), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_bank_addr"}, 64'(bank_addr), 64'd0);
        chk({pfx, "_bank_data"}, 64'(bank_data), 64'd0);
        chk({pfx, "_grant_id"}, 64'(grant_id), 64'd0);
    endtask

    initial begin
        int g;
        int prev;
        logic [15:0] rd;

        // Reset held with all requests asserted: nothing may be granted.
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a[i] = 3'(i + 1);
            d[i] = 16'hA0A0 + 16'(i);
        end
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");

        // Single write from requester 2.
        rst_n = 1'b1;
        a[2]  = 3'd5;
        d[2]  = 16'b1001001110011010;
        push_exp(2, 3'd5, 16'h939A);
        req   = 4'b0100;
        wait_ack(g);
        chk("single_grant", 64'(g), 64'd2);
        req = 4'b0000;
        @(negedge clk);
        chk("single_load_low", 64'(bank_load), 64'd0);
        chk("single_bank5", 64'(bank_m[5]), 64'h939A);

        // Round-robin with all requesters held high, starting from ptr=0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[i] = 3'(i);
            rd   = 16'($urandom);
            d[i] = rd;
        end
        for (int n = 0; n < 8; n++) push_exp(n % 4, a[n % 4], d[n % 4]);
        req  = 4'b1111;
        prev = 0;
        for (int n = 0; n < 8; n++) begin
            wait_ack(g);
            chk("rr_order", 64'(g), 64'(n % 4));
            if (n > 0) chk("rr_spacing", 64'(cyc - prev), 64'd2);
            prev = cyc;
        end
        req = 4'b0000;
        @(negedge clk);
        chk("rr_queue_drained", 64'(q.size()), 64'd0);

        // Pointer wrap: 3, then 0 ahead of 3 again.
        a[3] = 3'd7; d[3] = 16'h3C3C;
        a[0] = 3'd1; d[0] = 16'h0F0F;
        push_exp(3, 3'd7, 16'h3C3C);
        push_exp(0, 3'd1, 16'h0F0F);
        push_exp(3, 3'd7, 16'h3C3C);
        req = 4'b1000;
        wait_ack(g);
        chk("wrap_first", 64'(g), 64'd3);
        req = 4'b1001;
        wait_ack(g);
        chk("wrap_second", 64'(g), 64'd0);
        req = 4'b1000;
        wait_ack(g);
        chk("wrap_third", 64'(g), 64'd3);
        req = 4'b0000;
        @(negedge clk);

        // Back-to-back writes from requester 1 with data changed after ack.
        a[1] = 3'd6; d[1] = 16'hFFFF;
        push_exp(1, 3'd6, 16'hFFFF);
        push_exp(1, 3'd6, 16'hCED8);
        req = 4'b0010;
        wait_ack(g);
        chk("b2b_first", 64'(g), 64'd1);
        prev = cyc;
        d[1] = 16'hCED8;
        wait_ack(g);
        chk("b2b_second", 64'(g), 64'd1);
        chk("b2b_spacing", 64'(cyc - prev), 64'd2);
        req = 4'b0000;
        @(negedge clk);
        chk("b2b_bank6", 64'(bank_m[6]), 64'hCED8);

        // Reset asserted during requester 0's write cycle.
        a[0] = 3'd2; d[0] = 16'h1234;
        push_exp(0, 3'd2, 16'h1234);
        req = 4'b0001;
        wait_ack(g);
        chk("rstw_grant", 64'(g), 64'd0);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        chk_outputs_zero("rstw");
        chk("rstw_bank2", 64'(bank_m[2]), 64'h1234);

        // Pointer must be back at 0: with all requesting, 0 wins first.
        rst_n = 1'b1;
        a[0] = 3'd4; d[0] = 16'h5A5A;
        push_exp(0, 3'd4, 16'h5A5A);
        req = 4'b1111;
        wait_ack(g);
        chk("rstw_ptr_zero", 64'(g), 64'd0);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("final_queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
